// File: rtl/i2c_pkg.sv
// Shared I2C master definitions: bit-engine commands, byte commands, byte-sequencer states.
package i2c_pkg;

    localparam int unsigned STEP_W = 3;
    localparam int unsigned BYTE_CMD_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef logic [STEP_W-1:0]     bit_cmd_t;
    typedef logic [BYTE_CMD_W-1:0] byte_cmd_t;

    localparam bit_cmd_t BIT_NONE  = 3'b000;
    localparam bit_cmd_t BIT_READ  = 3'b001;
    localparam bit_cmd_t BIT_START = 3'b010;
    localparam bit_cmd_t BIT_STOP  = 3'b011;
    localparam bit_cmd_t BIT_D0    = 3'b100;
    localparam bit_cmd_t BIT_D1    = 3'b101;
    localparam bit_cmd_t BIT_ACK   = 3'b110;
    localparam bit_cmd_t BIT_NACK  = 3'b111;

    localparam byte_cmd_t CMD_START     = 3'b001;
    localparam byte_cmd_t CMD_STOP      = 3'b010;
    localparam byte_cmd_t CMD_WRITE     = 3'b011;
    localparam byte_cmd_t CMD_READ_ACK  = 3'b100;
    localparam byte_cmd_t CMD_READ_NACK = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // True for the five byte commands the sequencer knows how to run.
    function automatic logic cmd_legal(input byte_cmd_t cmd);
        return cmd inside {CMD_START, CMD_STOP, CMD_WRITE, CMD_READ_ACK, CMD_READ_NACK};
    endfunction

    // Bit-engine command for step idx of a byte command; tx_msb is the next TX data bit.
    function automatic bit_cmd_t step_cmd(input byte_cmd_t cmd, input logic [CNT_W-1:0] idx,
                                          input logic tx_msb);
        bit_cmd_t c;
        c = BIT_NONE;
        case (cmd)
            CMD_START:     c = BIT_START;
            CMD_STOP:      c = BIT_STOP;
            CMD_WRITE: begin
                if (idx < CNT_W'(8))       c = tx_msb ? BIT_D1 : BIT_D0;
                else if (idx == CNT_W'(8)) c = BIT_READ;
                else                       c = BIT_STOP;
            end
            CMD_READ_ACK:  c = (idx < CNT_W'(8)) ? BIT_READ : BIT_ACK;
            CMD_READ_NACK: c = (idx < CNT_W'(8)) ? BIT_READ : BIT_NACK;
            default:       c = BIT_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/i2c_shift8.sv
// 8-bit MSB-first shift register with parallel load; shared by TX and RX paths.
module i2c_shift8 (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       shift_en,
    input  logic       shift_in,
    output logic [7:0] q,
    output logic       shift_out
);

    // Load has priority over shift; shift moves toward the MSB, new bit enters at the LSB.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= 8'h00;
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= {q[6:0], shift_in};
        end
    end

    assign shift_out = q[7];

endmodule

// File: rtl/i2c_master_byte.sv
// Byte-level I2C sequencer: splits one byte command into bit-engine commands.
// Optional: I2C_MASTER_NACK_STOP_EN appends a STOP step to a WRITE that sees NACK.
module i2c_master_byte
    import i2c_pkg::*;
#(
    parameter int unsigned BIT_CMD_W = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 go,
    input  logic [2:0]           command,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    output logic                 ack_received,
    output logic                 cmd_error,
    output logic                 finish,
    output logic                 bit_go,
    output logic [BIT_CMD_W-1:0] bit_command,
    input  logic                 bit_finish,
    input  logic                 bit_rx
);

`ifdef I2C_MASTER_NACK_STOP_EN
    localparam bit NACK_STOP_EN = 1'b1;
`else
    localparam bit NACK_STOP_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    byte_cmd_t        cmd_q, cmd_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    bit_cmd_t         bit_cmd_q, bit_cmd_d;
    logic             ack_q, ack_d;
    logic             armed_q, armed_d;
    logic             bit_go_d, finish_d, cmd_error_d, ack_received_d;
    logic [7:0]       data_out_d;
    logic             sr_load, sr_shift, sr_msb, step_last;
    logic [7:0]       sr_q;

    i2c_shift8 u_shift (
        .clock     (clock),
        .reset     (reset),
        .load      (sr_load),
        .load_val  (data_in),
        .shift_en  (sr_shift),
        .shift_in  (bit_rx),
        .q         (sr_q),
        .shift_out (sr_msb)
    );

    assign bit_command = BIT_CMD_W'(bit_cmd_q);

    // Next-state and next-output logic; bit_go/bit_command are set on entry to ISSUE.
    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        bit_cnt_d      = bit_cnt_q;
        ack_d          = ack_q;
        armed_d        = armed_q;
        bit_go_d       = bit_go;
        bit_cmd_d      = bit_cmd_q;
        finish_d       = 1'b0;
        cmd_error_d    = cmd_error;
        data_out_d     = data_out;
        ack_received_d = ack_received;
        sr_load        = 1'b0;
        sr_shift       = 1'b0;
        step_last      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go && !finish && armed_q) begin
                    cmd_d     = command;
                    bit_cnt_d = '0;
                    ack_d     = 1'b0;
                    sr_load   = 1'b1;
                    if (cmd_legal(command)) begin
                        cmd_error_d = 1'b0;
                        bit_go_d    = 1'b1;
                        bit_cmd_d   = step_cmd(command, CNT_W'(0), data_in[7]);
                        state_d     = ST_ISSUE;
                    end else begin
                        // Illegal command completes immediately without touching the bus.
                        cmd_error_d = 1'b1;
                        finish_d    = 1'b1;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bit_finish) begin
                    bit_go_d = 1'b0;
                    if (bit_cnt_q < CNT_W'(8)) sr_shift = 1'b1;
                    if (cmd_q == CMD_WRITE && bit_cnt_q == CNT_W'(8)) ack_d = ~bit_rx;
                    if (cmd_q == CMD_START || cmd_q == CMD_STOP) begin
                        step_last = 1'b1;
                    end else if (bit_cnt_q == CNT_W'(8)) begin
                        step_last = !(NACK_STOP_EN && cmd_q == CMD_WRITE && bit_rx);
                    end else begin
                        step_last = (bit_cnt_q >= CNT_W'(9));
                    end
                    state_d = step_last ? ST_DONE : ST_NEXT;
                end
            end
            ST_NEXT: begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                bit_go_d  = 1'b1;
                bit_cmd_d = step_cmd(cmd_q, bit_cnt_d, sr_msb);
                state_d   = ST_ISSUE;
            end
            ST_DONE: begin
                finish_d = 1'b1;
                if (cmd_q == CMD_READ_ACK || cmd_q == CMD_READ_NACK) data_out_d = sr_q;
                if (cmd_q == CMD_WRITE) ack_received_d = ack_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A new accept needs go to have been seen low since the last finish.
        if (finish_d) armed_d = 1'b0;
        else if (!go) armed_d = 1'b1;
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            bit_cnt_q    <= '0;
            bit_cmd_q    <= BIT_NONE;
            ack_q        <= 1'b0;
            armed_q      <= 1'b1;
            bit_go       <= 1'b0;
            finish       <= 1'b0;
            cmd_error    <= 1'b0;
            data_out     <= 8'h00;
            ack_received <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_cmd_q    <= bit_cmd_d;
            ack_q        <= ack_d;
            armed_q      <= armed_d;
            bit_go       <= bit_go_d;
            finish       <= finish_d;
            cmd_error    <= cmd_error_d;
            data_out     <= data_out_d;
            ack_received <= ack_received_d;
        end
    end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Self-checking bench for i2c_master_byte with a bit-engine responder of configurable latency.
`timescale 1ns/1ps
module tb_i2c_master_byte;

    localparam int unsigned BIT_CMD_W = 3;

`ifdef I2C_MASTER_NACK_STOP_EN
    localparam bit NACK_STOP = 1'b1;
`else
    localparam bit NACK_STOP = 1'b0;
`endif

    localparam logic [2:0] B_READ = 3'b001, B_START = 3'b010, B_STOP = 3'b011, B_D0 = 3'b100,
                           B_D1 = 3'b101, B_ACK = 3'b110, B_NACK = 3'b111;
    localparam logic [2:0] C_START = 3'b001, C_STOP = 3'b010, C_WRITE = 3'b011,
                           C_RACK = 3'b100, C_RNACK = 3'b101;

    logic clock = 1'b0;
    logic reset, go, bit_finish, bit_rx;
    logic [2:0] command;
    logic [7:0] data_in, data_out;
    logic ack_received, cmd_error, finish, bit_go;
    logic [BIT_CMD_W-1:0] bit_command;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int eng_lat = 4;
    int bf_cyc_last = 0;
    int stab_err = 0;
    logic [2:0] log_cmd[$];
    int rise_cyc[$];
    int len_q[$];
    bit rx_q[$];
    logic [7:0] exp_data = 8'h00;
    logic exp_ack = 1'b0;

    i2c_master_byte #(.BIT_CMD_W(BIT_CMD_W)) dut (
        .clock(clock), .reset(reset), .go(go), .command(command), .data_in(data_in),
        .data_out(data_out), .ack_received(ack_received), .cmd_error(cmd_error),
        .finish(finish), .bit_go(bit_go), .bit_command(bit_command),
        .bit_finish(bit_finish), .bit_rx(bit_rx)
    );

    initial forever #5 clock = ~clock;
    initial forever begin @(posedge clock); cyc++; end

    // Bus monitor plus bit-engine model: bit_finish arrives eng_lat cycles after bit_go rises.
    initial begin
        bit busy;
        bit prev_go;
        int cnt;
        int run;
        logic [2:0] cur;
        busy = 0; prev_go = 0; cnt = 0; run = 0; cur = 3'b000;
        bit_finish = 1'b0; bit_rx = 1'b0;
        forever begin
            @(negedge clock);
            if (bit_go === 1'b1 && !prev_go) begin
                log_cmd.push_back(bit_command);
                rise_cyc.push_back(cyc);
                cur = bit_command;
                run = 0;
            end
            if (bit_go === 1'b1) begin
                run++;
                if (prev_go && bit_command !== cur) stab_err++;
            end else if (prev_go) begin
                len_q.push_back(run);
            end
            prev_go = (bit_go === 1'b1);
            if (bit_finish) begin
                bit_finish = 1'b0; bit_rx = 1'b0; busy = 0;
            end else if (busy && bit_go !== 1'b1) begin
                busy = 0; rx_q.delete();
            end else begin
                if (busy) cnt++;
                else if (bit_go === 1'b1) begin busy = 1; cnt = 1; end
                if (busy && cnt == eng_lat + 1) begin
                    bit_finish = 1'b1;
                    bf_cyc_last = cyc;
                    if (bit_command == B_READ) bit_rx = (rx_q.size() > 0) ? rx_q.pop_front() : 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One byte transaction: reference list of bit commands built straight from the command rules.
    task automatic do_txn(input logic [2:0] cmd, input logic [7:0] d, input bit ack_bit,
                          input logic [7:0] rd, input int lat, input bit keep_go, input string tag);
        logic [2:0] exp_q[$];
        bit legal;
        int acc, fin, k, rb, lb, sb;
        legal = (cmd >= 3'd1 && cmd <= 3'd5);
        case (cmd)
            C_START: exp_q.push_back(B_START);
            C_STOP:  exp_q.push_back(B_STOP);
            C_WRITE: begin
                for (int i = 7; i >= 0; i--) exp_q.push_back(d[i] ? B_D1 : B_D0);
                exp_q.push_back(B_READ);
                rx_q.push_back(ack_bit);
                if (NACK_STOP && ack_bit) exp_q.push_back(B_STOP);
            end
            C_RACK, C_RNACK: begin
                for (int i = 7; i >= 0; i--) begin
                    exp_q.push_back(B_READ);
                    rx_q.push_back(rd[i]);
                end
                exp_q.push_back(cmd == C_RACK ? B_ACK : B_NACK);
            end
            default: ;
        endcase
        eng_lat = lat;
        rb = rise_cyc.size(); lb = len_q.size(); sb = stab_err;
        @(negedge clock);
        go = 1'b1; command = cmd; data_in = d; acc = cyc;
        @(negedge clock);
        k = 0;
        while (finish !== 1'b1 && k < 3000) begin
            command = 3'($urandom);
            data_in = 8'($urandom);
            if (!keep_go && $urandom_range(0, 7) == 0) go = 1'b0;
            @(negedge clock);
            k++;
        end
        check({tag, ".finish_seen"}, finish, 1'b1);
        fin = cyc;
        if (!keep_go) go = 1'b0;
        if (cmd == C_WRITE) exp_ack = ~ack_bit;
        if (cmd == C_RACK || cmd == C_RNACK) exp_data = rd;
        check({tag, ".data_out"}, data_out, exp_data);
        check({tag, ".ack_received"}, ack_received, exp_ack);
        check({tag, ".cmd_error"}, cmd_error, !legal);
        if (legal) begin
            check({tag, ".bf_to_finish"}, fin - bf_cyc_last, 2);
            if (rise_cyc.size() > rb) check({tag, ".accept_to_go"}, rise_cyc[rb] - acc, 1);
        end else begin
            check({tag, ".accept_to_finish"}, fin - acc, 1);
        end
        @(negedge clock);
        check({tag, ".finish_pulse_1cyc"}, finish, 1'b0);
        if (keep_go) begin
            for (int i = 0; i < 6; i++) begin
                @(negedge clock);
                check({tag, ".no_reaccept_finish"}, finish, 1'b0);
            end
            go = 1'b0;
        end
        repeat (2) @(negedge clock);
        check({tag, ".n_steps"}, rise_cyc.size() - rb, exp_q.size());
        for (int i = 0; i < exp_q.size() && rb + i < log_cmd.size(); i++)
            check($sformatf("%s.step%0d_cmd", tag, i), log_cmd[rb + i], exp_q[i]);
        for (int i = 0; lb + i < len_q.size(); i++)
            check($sformatf("%s.step%0d_go_len", tag, i), len_q[lb + i], lat + 1);
        for (int i = 1; rb + i < rise_cyc.size() && lb + i - 1 < len_q.size(); i++)
            check($sformatf("%s.step%0d_gap", tag, i),
                  rise_cyc[rb + i] - rise_cyc[rb + i - 1] - len_q[lb + i - 1], 1);
        check({tag, ".cmd_stable"}, stab_err - sb, 0);
    endtask

    initial begin
        int rb, k;
        logic [2:0] rc;
        reset = 1'b1; go = 1'b0; command = 3'b000; data_in = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset.bit_go", bit_go, 1'b0);
        check("reset.bit_command", bit_command, 3'b000);
        check("reset.finish", finish, 1'b0);
        check("reset.data_out", data_out, 8'h00);
        check("reset.ack_received", ack_received, 1'b0);
        check("reset.cmd_error", cmd_error, 1'b0);

        do_txn(C_START, 8'h00, 1'b0, 8'h00, 4, 1'b0, "start");
        do_txn(C_STOP, 8'h00, 1'b0, 8'h00, 4, 1'b0, "stop");
        do_txn(C_WRITE, 8'hA5, 1'b0, 8'h00, 4, 1'b0, "write_a5");
        do_txn(C_RNACK, 8'h00, 1'b0, 8'hCA, 3, 1'b0, "read_nack_ca");
        do_txn(C_WRITE, 8'h00, 1'b1, 8'h00, 2, 1'b0, "write_nack");
        do_txn(3'b111, 8'h5A, 1'b0, 8'h00, 2, 1'b0, "illegal_111");
        do_txn(3'b000, 8'h5A, 1'b0, 8'h00, 2, 1'b0, "illegal_000");
        do_txn(C_START, 8'h00, 1'b0, 8'h00, 1, 1'b1, "start_hold_go");

        for (int n = 0; n < 10; n++) begin
            rc = ($urandom_range(0, 7) == 0) ? 3'b110 : 3'($urandom_range(1, 5));
            do_txn(rc, 8'($urandom), 1'($urandom), 8'($urandom), $urandom_range(1, 6), 1'b0,
                   $sformatf("rand%0d", n));
        end

        do_txn(C_RACK, 8'h00, 1'b0, 8'h3C, 2, 1'b0, "read_ack_3c");
        do_txn(C_WRITE, 8'h81, 1'b0, 8'h00, 2, 1'b0, "write_81");

        // Reset during the fourth bit of a READ_ACK.
        eng_lat = 3;
        for (int i = 0; i < 8; i++) rx_q.push_back(1'($urandom));
        rb = rise_cyc.size();
        @(negedge clock);
        go = 1'b1; command = C_RACK; data_in = 8'hFF;
        k = 0;
        while (rise_cyc.size() < rb + 4 && k < 500) begin @(negedge clock); k++; end
        check("midreset.reached_bit4", rise_cyc.size() >= rb + 4, 1'b1);
        reset = 1'b1; go = 1'b0;
        @(negedge clock);
        check("midreset.bit_go", bit_go, 1'b0);
        check("midreset.bit_command", bit_command, 3'b000);
        check("midreset.data_out", data_out, 8'h00);
        check("midreset.ack_received", ack_received, 1'b0);
        check("midreset.finish", finish, 1'b0);
        reset = 1'b0;
        exp_data = 8'h00; exp_ack = 1'b0;
        repeat (3) @(negedge clock);
        check("midreset.no_stop_issued", rise_cyc.size() - rb, 4);
        do_txn(C_START, 8'h00, 1'b0, 8'h00, 4, 1'b0, "start_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
